// File: rtl/serial_comparator_nbit_pkg.sv
// Shared types and helpers for the serial MSB-first comparator.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } cmp_result_t;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_comparator_nbit_digit_cmp.sv
// Combinational DIGIT-bit unsigned magnitude compare, built as a per-bit
// equal/greater cascade rippling from the LSB up to the MSB.
module digit_cmp #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    output logic             d_eq,
    output logic             d_gt
);

    logic [DIGIT-1:0] bit_eq;
    logic [DIGIT-1:0] bit_gt;

    // Per-bit xnor / greater terms, then the cascade: a higher bit that is
    // equal passes the lower-order verdict through, otherwise it decides.
    always_comb begin
        logic gt_acc;
        logic eq_acc;
        gt_acc = 1'b0;
        eq_acc = 1'b1;
        for (int i = 0; i < DIGIT; i++) begin
            bit_eq[i] = ~(x[i] ^ y[i]);
            bit_gt[i] = x[i] & ~y[i];
            gt_acc    = bit_gt[i] | (bit_eq[i] & gt_acc);
            eq_acc    = eq_acc & bit_eq[i];
        end
        d_eq = eq_acc;
        d_gt = gt_acc;
    end

endmodule

// File: rtl/serial_comparator_nbit.sv
// Serial MSB-first comparator: examines DIGIT bits per clock and stops at the
// first differing digit. Signed operands are handled by flipping the MSBs.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; last result held on eq/gt/lt
// SCAN  | comparing digit cnt_q of the shifted operands, busy=1
// DONE  | one-cycle done pulse; a new start is accepted here as well
module serial_comparator_nbit
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_width(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    cmp_state_t  state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    cmp_result_t      res_q, res_d;

    logic d_eq;
    logic d_gt;

    digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
        .x    (a_sh_q[WIDTH-1 -: DIGIT]),
        .y    (b_sh_q[WIDTH-1 -: DIGIT]),
        .d_eq (d_eq),
        .d_gt (d_gt)
    );

    // Next-state, datapath and output-flop inputs.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        res_d   = res_q;
        case (state_q)
            IDLE, DONE: begin
                // abort in the same cycle drops the request
                if (start && !abort) begin
                    a_sh_d  = signed_mode ? {~a[WIDTH-1], a[WIDTH-2:0]} : a;
                    b_sh_d  = signed_mode ? {~b[WIDTH-1], b[WIDTH-2:0]} : b;
                    cnt_d   = '0;
                    res_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (abort) begin
                    res_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (!d_eq) begin
                    res_d.gt = d_gt;
                    res_d.lt = ~d_gt;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = DONE;
                end else if (cnt_q == LAST) begin
                    res_d.eq = 1'b1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = DONE;
                end else begin
                    a_sh_d = a_sh_q << DIGIT;
                    b_sh_d = b_sh_q << DIGIT;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            res_q   <= res_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign eq   = res_q.eq;
    assign gt   = res_q.gt;
    assign lt   = res_q.lt;

endmodule

// File: tb/tb_serial_comparator_nbit.sv
// Directed bench for serial_comparator_nbit: an 8-bit/2-bit instance and a
// 16-bit/4-bit instance share one clock.
module tb_serial_comparator_nbit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start8, sm8, abort8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, eq8, gt8, lt8;
    logic        start16, sm16, abort16;
    logic [15:0] a16, b16;
    logic        busy16, done16, eq16, gt16, lt16;

    serial_comparator_nbit #(.WIDTH(8), .DIGIT(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .abort(abort8),
        .busy(busy8), .done(done8), .eq(eq8), .gt(gt8), .lt(lt8)
    );

    serial_comparator_nbit #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16),
        .a(a16), .b(b16), .abort(abort16),
        .busy(busy16), .done(done16), .eq(eq16), .gt(gt16), .lt(lt16)
    );

    typedef struct {
        logic        wide;
        logic        sm;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  res;   // {eq, gt, lt}
        int          lat;
    } vec_t;

    localparam logic [2:0] R_EQ = 3'b100;
    localparam logic [2:0] R_GT = 3'b010;
    localparam logic [2:0] R_LT = 3'b001;

    vec_t vecs[14];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] res_of(input logic wide);
        return wide ? {eq16, gt16, lt16} : {eq8, gt8, lt8};
    endfunction

    function automatic logic busy_of(input logic wide);
        return wide ? busy16 : busy8;
    endfunction

    function automatic logic done_of(input logic wide);
        return wide ? done16 : done8;
    endfunction

    task automatic launch(input logic wide, input logic sm, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        if (wide) begin
            start16 = 1'b1; sm16 = sm; a16 = a; b16 = b;
        end else begin
            start8 = 1'b1; sm8 = sm; a8 = a[7:0]; b8 = b[7:0];
        end
        @(negedge clk);
        start8  = 1'b0;
        start16 = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int k;
        launch(v.wide, v.sm, v.a, v.b);
        chk($sformatf("v%0d busy_after_capture", idx), 32'(busy_of(v.wide)), 32'd1);
        chk($sformatf("v%0d res_cleared", idx), 32'(res_of(v.wide)), 32'd0);
        k = 0;
        while (!done_of(v.wide) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("v%0d latency", idx), 32'(k), 32'(v.lat));
        chk($sformatf("v%0d result", idx), 32'(res_of(v.wide)), 32'(v.res));
        chk($sformatf("v%0d busy_at_done", idx), 32'(busy_of(v.wide)), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d done_pulse_end", idx), 32'(done_of(v.wide)), 32'd0);
        chk($sformatf("v%0d result_held", idx), 32'(res_of(v.wide)), 32'(v.res));
    endtask

    task automatic watch_no_done(input string nm, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done8) seen++;
        end
        chk(nm, 32'(seen), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        start8 = 1'b0; sm8 = 1'b0; abort8 = 1'b0; a8 = '0; b8 = '0;
        start16 = 1'b0; sm16 = 1'b0; abort16 = 1'b0; a16 = '0; b16 = '0;

        vecs[0]  = '{1'b0, 1'b0, 16'h00A5, 16'h00A5, R_EQ, 4};
        vecs[1]  = '{1'b0, 1'b0, 16'h0080, 16'h007F, R_GT, 1};
        vecs[2]  = '{1'b0, 1'b1, 16'h0080, 16'h007F, R_LT, 1};
        vecs[3]  = '{1'b0, 1'b0, 16'h0034, 16'h0035, R_LT, 4};
        vecs[4]  = '{1'b0, 1'b0, 16'h0010, 16'h0020, R_LT, 2};
        vecs[5]  = '{1'b0, 1'b1, 16'h00FF, 16'h0000, R_LT, 1};
        vecs[6]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, R_EQ, 4};
        vecs[7]  = '{1'b0, 1'b0, 16'h000C, 16'h0008, R_GT, 3};
        vecs[8]  = '{1'b0, 1'b1, 16'h0081, 16'h0080, R_GT, 4};
        vecs[9]  = '{1'b0, 1'b1, 16'h00FE, 16'h00FF, R_LT, 4};
        vecs[10] = '{1'b1, 1'b1, 16'hFFFF, 16'h0001, R_LT, 1};
        vecs[11] = '{1'b1, 1'b0, 16'hFFFF, 16'h0001, R_GT, 1};
        vecs[12] = '{1'b1, 1'b0, 16'h1234, 16'h1234, R_EQ, 4};
        vecs[13] = '{1'b1, 1'b1, 16'h1230, 16'h1234, R_LT, 4};

        repeat (3) @(negedge clk);
        chk("reset8 outputs", 32'({busy8, done8, eq8, gt8, lt8}), 32'd0);
        chk("reset16 outputs", 32'({busy16, done16, eq16, gt16, lt16}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

        // start during busy is ignored; start in the done cycle is accepted
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b0; a8 = 8'h10; b8 = 8'h20;
        @(negedge clk);                       // E0 passed
        a8 = 8'hFF; b8 = 8'h00;               // start still high while busy
        @(negedge clk);                       // E1 passed
        start8 = 1'b0;
        chk("ignore busy_E1", 32'(busy8), 32'd1);
        @(negedge clk);                       // E2 passed
        chk("ignore done_E2", 32'(done8), 32'd1);
        chk("ignore result_lt", 32'({eq8, gt8, lt8}), 32'(R_LT));
        start8 = 1'b1;                        // in the done cycle
        @(negedge clk);                       // capture edge
        start8 = 1'b0;
        chk("restart busy", 32'({busy8, done8}), 32'b10);
        chk("restart res_cleared", 32'({eq8, gt8, lt8}), 32'd0);
        @(negedge clk);
        chk("restart done", 32'(done8), 32'd1);
        chk("restart result_gt", 32'({eq8, gt8, lt8}), 32'(R_GT));
        repeat (2) @(negedge clk);

        // synchronous reset mid-scan
        launch(1'b0, 1'b0, 16'h0055, 16'h0055);   // E0 passed
        @(negedge clk);                            // E1 passed
        rst_n = 1'b0;
        @(negedge clk);                            // E2 resets
        chk("midreset outputs", 32'({busy8, done8, eq8, gt8, lt8}), 32'd0);
        rst_n = 1'b1;
        watch_no_done("midreset no_done", 6);

        // abort mid-scan
        launch(1'b0, 1'b0, 16'h0055, 16'h0055);   // E0 passed
        @(negedge clk);                            // E1 passed
        chk("abort busy_before", 32'(busy8), 32'd1);
        abort8 = 1'b1;
        @(negedge clk);                            // E2 takes the abort
        abort8 = 1'b0;
        chk("abort outputs", 32'({busy8, done8, eq8, gt8, lt8}), 32'd0);
        watch_no_done("abort no_done", 6);

        // abort while idle does nothing; abort beats start when idle
        run_vec('{1'b0, 1'b0, 16'h0009, 16'h0003, R_GT, 3}, 100);
        @(negedge clk);
        abort8 = 1'b1;
        @(negedge clk);
        abort8 = 1'b0;
        chk("idle_abort result_held", 32'({busy8, eq8, gt8, lt8}), 32'(R_GT));
        start8 = 1'b1; abort8 = 1'b1; a8 = 8'h01; b8 = 8'h02;
        @(negedge clk);
        start8 = 1'b0; abort8 = 1'b0;
        chk("abort_start dropped", 32'({busy8, eq8, gt8, lt8}), 32'(R_GT));
        watch_no_done("abort_start no_done", 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
